// File: rtl/gate_resp_checker_if.sv
// Sample stream from the stimulus side: one valid-qualified (in1, in2, out) triple per cycle.
// No ready signal: the checker takes every sample presented while a run is active.
interface gate_resp_checker_if;
  logic in_vld;
  logic in1;
  logic in2;
  logic out;

  modport master (output in_vld, in1, in2, out);
  modport slave  (input  in_vld, in1, in2, out);
endinterface

// File: rtl/gate_resp_checker.sv
// Gate response checker: compares each (in1,in2,out) sample against AND/OR/XOR/NAND, 1-cycle to counters.
// Never stalls the sample stream; optional watchdog under GATE_CHK_TIMEOUT_EN.
module gate_resp_checker #(
  parameter int CNT_W       = 8,
  parameter int EXP_VECTORS = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  gate_resp_checker_if.slave    smp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      vec_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  first_err_vld,
  output logic [1:0]            first_err_in,
  output logic                  first_err_out,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] vin;
    logic       vout;
  } ferr_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXP_VECTORS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  ferr_t            ferr_q;
  logic             start_acc;
  logic             smp_acc;
  logic             exp_bit;
  logic             mis;
  logic             last_smp;
  logic             wd_fire;

  assign start_acc = start & (state_q != RUN);
  assign smp_acc   = smp.in_vld & (state_q == RUN);
  assign last_smp  = smp_acc & (vec_cnt == EXP_LAST);

  always_comb begin
    exp_bit = 1'b0;
    case (op_q)
      2'b00:   exp_bit = smp.in1 & smp.in2;
      2'b01:   exp_bit = smp.in1 | smp.in2;
      2'b10:   exp_bit = smp.in1 ^ smp.in2;
      default: exp_bit = ~(smp.in1 & smp.in2);
    endcase
  end

  // Case equality so an X on out is scored as a mismatch rather than silently dropped.
  assign mis = smp_acc & ~(smp.out === exp_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_smp || wd_fire) state_d = DONE;
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    pass = (state_q == DONE) & (err_cnt == '0) & ~timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 2'b00;
      vec_cnt <= '0;
      err_cnt <= '0;
      ferr_q  <= '0;
    end else if (start_acc) begin
      op_q    <= op;
      vec_cnt <= '0;
      err_cnt <= '0;
      ferr_q  <= '0;
    end else if (smp_acc) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mis) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        if (!ferr_q.vld) begin
          ferr_q.vld  <= 1'b1;
          ferr_q.vin  <= {smp.in1, smp.in2};
          ferr_q.vout <= smp.out;
        end
      end
    end
  end

  assign first_err_vld = ferr_q.vld;
  assign first_err_in  = ferr_q.vin;
  assign first_err_out = ferr_q.vout;

`ifdef GATE_CHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            to_q;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle of a run.
  assign wd_fire = (state_q == RUN) & ~smp.in_vld & (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (start_acc) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (smp.in_vld) begin
        wd_q <= '0;
      end else if (wd_fire) begin
        to_q <= 1'b1;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  assign timeout = to_q;
`else
  assign wd_fire = 1'b0;
  // Always 0; the parameter is referenced so both builds share one parameter list.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed and randomized bench for gate_resp_checker against a truth-table reference model.
module tb_gate_resp_checker;

  typedef struct packed {
    logic a;
    logic b;
    logic o;
  } smp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       busy, done, pass, fe_vld, fe_out, tmo;
  logic [7:0] vec_cnt, err_cnt;
  logic [1:0] fe_in;

  logic       start5 = 1'b0;
  logic [1:0] op5 = 2'b00;
  logic       busy5, done5, pass5, fe_vld5, fe_out5, tmo5;
  logic [1:0] vec5, err5;
  logic [1:0] fe_in5;

  gate_resp_checker_if sif();
  gate_resp_checker_if sif5();

  gate_resp_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .smp(sif),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_vld(fe_vld), .first_err_in(fe_in), .first_err_out(fe_out), .timeout(tmo)
  );

  gate_resp_checker #(.CNT_W(2), .EXP_VECTORS(3)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .op(op5), .smp(sif5),
    .busy(busy5), .done(done5), .pass(pass5), .vec_cnt(vec5), .err_cnt(err5),
    .first_err_vld(fe_vld5), .first_err_in(fe_in5), .first_err_out(fe_out5), .timeout(tmo5)
  );

  int         checks = 0;
  int         failures = 0;
  logic [1:0] cur_op = 2'b00;
  smp_t       sq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth tables indexed by {a,b}: AND, OR, XOR, NAND.
  function automatic logic ref_fn(input logic [1:0] o, input logic a, input logic b);
    logic [3:0] tt [4];
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
    return tt[o][{a, b}];
  endfunction

  task automatic arm(input logic [1:0] o);
    start = 1'b1;
    op = o;
    tick();
    start = 1'b0;
    op = 2'($urandom);
    cur_op = o;
    sq.delete();
  endtask

  task automatic send(input logic a, input logic b, input logic o);
    sif.in_vld = 1'b1;
    sif.in1 = a;
    sif.in2 = b;
    sif.out = o;
    tick();
    sif.in_vld = 1'b0;
    sif.out = 1'($urandom);
    sq.push_back('{a, b, o});
  endtask

  task automatic send_good(input logic a, input logic b);
    send(a, b, ref_fn(cur_op, a, b));
  endtask

  task automatic send5(input logic a, input logic b, input logic o);
    sif5.in_vld = 1'b1;
    sif5.in1 = a;
    sif5.in2 = b;
    sif5.out = o;
    tick();
    sif5.in_vld = 1'b0;
  endtask

  task automatic check_result(input string tag);
    int         errs = 0;
    logic       fv = 1'b0;
    logic [1:0] fi = 2'b00;
    logic       fo = 1'b0;
    foreach (sq[i]) begin
      if (sq[i].o !== ref_fn(cur_op, sq[i].a, sq[i].b)) begin
        errs++;
        if (!fv) begin
          fv = 1'b1;
          fi = {sq[i].a, sq[i].b};
          fo = sq[i].o;
        end
      end
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".vec"}, vec_cnt, sq.size());
    chk({tag, ".err"}, err_cnt, (errs > 255) ? 255 : errs);
    chk({tag, ".fe_vld"}, fe_vld, fv);
    chk({tag, ".fe_in"}, fe_in, fi);
    chk({tag, ".fe_out"}, fe_out, fo);
    chk({tag, ".pass"}, pass, errs == 0);
    chk({tag, ".timeout"}, tmo, 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".vec"}, vec_cnt, 0);
    chk({tag, ".err"}, err_cnt, 0);
    chk({tag, ".fe_vld"}, fe_vld, 0);
    chk({tag, ".fe_in"}, fe_in, 0);
    chk({tag, ".fe_out"}, fe_out, 0);
    chk({tag, ".timeout"}, tmo, 0);
  endtask

  initial begin
    sif.in_vld = 1'b0; sif.in1 = 1'b0; sif.in2 = 1'b0; sif.out = 1'b0;
    sif5.in_vld = 1'b0; sif5.in1 = 1'b0; sif5.in2 = 1'b0; sif5.out = 1'b0;

    // Reset state, then in_vld ignored while idle.
    tick();
    tick();
    check_cleared("reset");
    rst = 1'b0;
    sif.in_vld = 1'b1;
    sif.out = 1'b1;
    tick();
    sif.in_vld = 1'b0;
    chk("idle.vec", vec_cnt, 0);
    chk("idle.busy", busy, 0);

    // 1: OR, all correct.
    arm(2'b01);
    chk("t1.busy_after_start", busy, 1);
    send(0, 0, 0);
    send(0, 1, 1);
    send(1, 0, 1);
    chk("t1.busy_mid", busy, 1);
    chk("t1.done_mid", done, 0);
    send(1, 1, 1);
    check_result("t1");

    // Samples in DONE are ignored.
    sif.in_vld = 1'b1; sif.in1 = 1'b1; sif.in2 = 1'b1; sif.out = 1'b0;
    tick();
    sif.in_vld = 1'b0;
    chk("done_hold.vec", vec_cnt, 4);
    chk("done_hold.err", err_cnt, 0);

    // 2: OR with the 10 sample reporting 0.
    arm(2'b01);
    send(0, 0, 0);
    send(0, 1, 1);
    send(1, 0, 0);
    send(1, 1, 1);
    check_result("t2");
    chk("t2.fe_in_const", fe_in, 2'b10);

    // 3: XOR with idle gaps and an ignored mid-run start.
    arm(2'b10);
    for (int i = 0; i < 4; i++) begin
      send_good(i[1], i[0]);
      if (i < 3) begin
        chk("t3.not_done", done, 0);
        for (int k = 0; k < 3; k++) begin
          start = (i == 1 && k == 0);
          op = 2'b00;
          tick();
        end
        start = 1'b0;
      end
    end
    check_result("t3");

    // 4: reset mid-run discards everything.
    arm(2'b00);
    send_good(1, 1);
    send_good(0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("t4.rst");
    arm(2'b00);
    for (int i = 0; i < 4; i++) send_good(i[1], i[0]);
    check_result("t4");

    // Start with a simultaneous sample from DONE: sample not counted.
    start = 1'b1; op = 2'b11;
    sif.in_vld = 1'b1; sif.in1 = 1'b1; sif.in2 = 1'b1; sif.out = 1'b1;
    tick();
    start = 1'b0;
    sif.in_vld = 1'b0;
    cur_op = 2'b11;
    sq.delete();
    chk("simul.vec", vec_cnt, 0);
    chk("simul.busy", busy, 1);
    for (int i = 0; i < 4; i++) send_good(i[0], i[1]);
    check_result("simul");

    // Randomized runs: random ops, gaps, wrong outputs, start/op noise.
    for (int r = 0; r < 12; r++) begin
      arm(2'($urandom));
      for (int k = 0; k < 4; k++) begin
        int gap;
        logic a, b;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          start = 1'($urandom);
          op = 2'($urandom);
          tick();
        end
        start = 1'b0;
        a = 1'($urandom);
        b = 1'($urandom);
        send(a, b, ref_fn(cur_op, a, b) ^ ($urandom_range(0, 3) == 0));
      end
      check_result("rand");
    end

    // 5: narrow counters, all samples wrong.
    start5 = 1'b1; op5 = 2'b00;
    tick();
    start5 = 1'b0; op5 = 2'b10;
    send5(0, 1, 1);
    chk("t5.err1", err5, 1);
    send5(1, 1, 0);
    chk("t5.err2", err5, 2);
    send5(0, 0, 1);
    chk("t5.err", err5, 3);
    chk("t5.vec", vec5, 3);
    chk("t5.done", done5, 1);
    chk("t5.pass", pass5, 0);
    chk("t5.fe_vld", fe_vld5, 1);
    chk("t5.fe_in", fe_in5, 2'b01);
    chk("t5.fe_out", fe_out5, 1);
    send5(1, 0, 1);
    chk("t5.err_hold", err5, 3);
    chk("t5.timeout", tmo5, 0);

    // 6: sample stream stops after one sample.
    arm(2'b11);
    send_good(1, 0);
    repeat (15) tick();
    chk("t6.busy_15", busy, 1);
    tick();
`ifdef GATE_CHK_TIMEOUT_EN
    chk("t6.done", done, 1);
    chk("t6.timeout", tmo, 1);
    chk("t6.pass", pass, 0);
    chk("t6.vec", vec_cnt, 1);
    chk("t6.err", err_cnt, 0);
    arm(2'b00);
    chk("t6.timeout_clr", tmo, 0);
    chk("t6.rearm_busy", busy, 1);
`else
    chk("t6.busy", busy, 1);
    chk("t6.done", done, 0);
    chk("t6.timeout", tmo, 0);
    chk("t6.vec", vec_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
Hardware response checker for two-input gate blocks; it is the receiving end of the stimulus stream that drives in1/in2 into a gate under test. Each valid sample (in1, in2, out) is compared against the expected result of the selected logic function. The block counts vectors and mismatches, captures the first failing vector, and reports pass/fail when the run completes. It sits beside a gate DUT in self-checking simulation and on-board bring-up.

Parameters:
CNT_W, 8, width of the vector and error counters.
EXP_VECTORS, 4, number of valid samples per run; legal range 1 to 2^CNT_W-1.
TIMEOUT_CYC, 16, idle-cycle limit while running; used only with GATE_CHK_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle pulse that arms a run.
op  input  2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled on accepted start.
in_vld  input  1  sample valid.
in1  input  1  gate input A of the sample.
in2  input  1  gate input B of the sample.
out  input  1  DUT output of the sample.
busy  output  1  high in RUN.
done  output  1  high in DONE.
pass  output  1  done AND err_cnt==0.
vec_cnt  output  CNT_W  accepted samples this run.
err_cnt  output  CNT_W  mismatches this run; saturating.
first_err_vld  output  1  a mismatch has been captured this run.
first_err_in  output  2  {in1,in2} of the first mismatch.
first_err_out  output  1  out of the first mismatch.
timeout  output  1  run ended by watchdog; constant 0 without the macro.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE. Every output is 0, including counters, first_err_* and timeout. The latched op is cleared to 00.
- FSM states are IDLE, RUN and DONE.
- IDLE: in_vld is ignored. On start=1 the block latches op, clears vec_cnt, err_cnt, first_err_* and timeout, then enters RUN on the next edge.
- RUN: when in_vld=1, the expected value is computed from the latched op, in1 and in2. It is compared with out, and the result is registered at the next edge (1-cycle latency to counters and flags).
  - vec_cnt increments by 1.
  - On a mismatch, err_cnt increments, holding at 2^CNT_W-1 once it reaches that value.
  - On the first mismatch, the block sets first_err_vld and captures first_err_in/first_err_out. Later mismatches do not overwrite them.
- Run end: the sample that makes vec_cnt reach EXP_VECTORS moves the FSM to DONE on the same edge. done and busy update on that edge.
- start during RUN is ignored. op changes during RUN are ignored.
- DONE: counters and flags hold, and done=1. start=1 re-arms exactly as from IDLE and goes directly to RUN. in_vld is ignored.
- Simultaneous start and in_vld in IDLE or DONE: the sample is not counted; the run begins next cycle.
- rst asserted mid-run: all state returns to reset values on that edge and partial results are discarded.
- The NAND expected value is ~(in1&in2). No X-propagation handling is required: X on out counts as a mismatch in simulation.

Optional Feature:
GATE_CHK_TIMEOUT_EN
- Defined: a watchdog counter runs in RUN. It clears on every accepted in_vld and on entry to RUN. After TIMEOUT_CYC consecutive cycles without in_vld, the FSM goes to DONE with timeout=1. pass is then forced to 0 regardless of err_cnt. timeout clears on the next accepted start or on rst.
- Not defined: no watchdog logic is present, timeout is tied to 0, and RUN waits indefinitely for samples.

Test Plan:
1. op=01, start, then 4 samples 00->0, 01->1, 10->1, 11->1 -> done=1, pass=1, vec_cnt=4, err_cnt=0, first_err_vld=0.
2. op=01, 4 samples with sample 10 reporting out=0 -> err_cnt=1, first_err_vld=1, first_err_in=2'b10, first_err_out=0, pass=0.
3. op=10 with 3 idle cycles between each of 4 correct XOR samples, plus a start pulse mid-run -> done only after the 4th sample, vec_cnt=4, pass=1, start ignored.
4. rst pulse after 2 samples of a run, then a new start and 4 correct AND samples -> all outputs 0 after the reset edge, then pass=1, vec_cnt=4.
5. CNT_W=2, EXP_VECTORS=3, op=00, all 3 samples wrong -> err_cnt saturates at 3, first_err_in holds the first vector, pass=0.
6. With GATE_CHK_TIMEOUT_EN: start, 1 sample, then no in_vld for 16 cycles -> done=1, timeout=1, pass=0, vec_cnt=1. Without the macro: busy stays 1 and timeout=0.
